// File: rtl/instruction_decode_pkg.sv
// Shared opcode constants and small decode helpers for the instruction decode stage.
// Opcode values are the codebase-wide encoding; the decode FSM encoding stays local to the top.
package instruction_decode_pkg;

    localparam logic [5:0] R_TYPE_OPCODE = 6'h00;
    localparam logic [5:0] BEQZ_OPCODE   = 6'h04;
    localparam logic [5:0] BNEZ_OPCODE   = 6'h05;
    localparam logic [5:0] ADDI_OPCODE   = 6'h08;
    localparam logic [5:0] SUBI_OPCODE   = 6'h09;
    localparam logic [5:0] ANDI_OPCODE   = 6'h0C;
    localparam logic [5:0] ORI_OPCODE    = 6'h0D;
    localparam logic [5:0] LW_OPCODE     = 6'h23;
    localparam logic [5:0] SW_OPCODE     = 6'h2B;

    localparam int IMM_WIDTH = 16;

    // Arithmetic and address-forming immediates are signed; logical immediates are not.
    function automatic logic imm_is_signed(input logic [5:0] opcode);
        case (opcode)
            ADDI_OPCODE, SUBI_OPCODE, LW_OPCODE, SW_OPCODE: imm_is_signed = 1'b1;
            default:                                        imm_is_signed = 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [5:0] opcode);
        case (opcode)
            R_TYPE_OPCODE, ADDI_OPCODE, SUBI_OPCODE,
            ANDI_OPCODE, ORI_OPCODE, LW_OPCODE:             writes_rd = 1'b1;
            default:                                        writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic has_imm_operand(input logic [5:0] opcode);
        case (opcode)
            ADDI_OPCODE, SUBI_OPCODE, ANDI_OPCODE,
            ORI_OPCODE, LW_OPCODE, SW_OPCODE:               has_imm_operand = 1'b1;
            default:                                        has_imm_operand = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instruction_decode_imm_extend.sv
// Widens a 16-bit instruction immediate to the datapath width, sign- or zero-extending.
module imm_extend
    import instruction_decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [IMM_WIDTH-1:0]  imm,
    input  logic                  sign_select,
    output logic [DATA_WIDTH-1:0] imm_ext
);

    // Replicate the immediate sign bit only when the consumer wants a signed value.
    always_comb begin
        imm_ext = '0;
        if (sign_select) begin
            imm_ext = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
        end else begin
            imm_ext = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm};
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: splits the fetched instruction, forms ALU operands and control bits,
// and inserts a single bubble on a load-use dependency.
module instruction_decode
    import instruction_decode_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_WIDTH   = 6,
    parameter int FUNCTION_WIDTH = 6,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     instr_in,
    input  logic                      instr_valid_in,
    output logic                      instr_ready_out,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_a_out,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_b_out,
    input  logic [DATA_WIDTH-1:0]     rf_data_a_in,
    input  logic [DATA_WIDTH-1:0]     rf_data_b_in,
    input  logic                      ex_ready_in,
    input  logic                      flush_in,
    output logic                      valid_out,
    output logic [OPCODE_WIDTH-1:0]   alu_opcode_out,
    output logic [FUNCTION_WIDTH-1:0] alu_function_out,
    output logic [DATA_WIDTH-1:0]     alu_data_a_out,
    output logic [DATA_WIDTH-1:0]     alu_data_b_out,
    output logic [DATA_WIDTH-1:0]     store_data_out,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_out,
    output logic                      reg_write_out,
    output logic                      mem_read_out,
    output logic                      mem_write_out
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } dec_state_t;

    dec_state_t state_r, state_nxt_s;

    logic [OPCODE_WIDTH-1:0]   opcode_s;
    logic [FUNCTION_WIDTH-1:0] funct_s;
    logic [REG_ADDR_WIDTH-1:0] rs1_s, rs2_s, rd_s;
    logic [IMM_WIDTH-1:0]      imm_s;
    logic [DATA_WIDTH-1:0]     imm_ext_s;
    logic                      is_rtype_s, is_load_s, is_store_s, uses_rs2_s;
    logic                      hazard_s, accept_s, load_en_s;
    logic                      unused_bits_s;

    logic                      trk_load_r;
    logic [REG_ADDR_WIDTH-1:0] trk_rd_r;

    logic [OPCODE_WIDTH-1:0]   nxt_opcode_s;
    logic [FUNCTION_WIDTH-1:0] nxt_funct_s;
    logic [DATA_WIDTH-1:0]     nxt_alu_a_s, nxt_alu_b_s, nxt_store_s;
    logic [REG_ADDR_WIDTH-1:0] nxt_rd_s;
    logic                      nxt_reg_write_s, nxt_mem_read_s, nxt_mem_write_s;

    assign opcode_s      = instr_in[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign rs1_s         = instr_in[25:21];
    assign rs2_s         = instr_in[20:16];
    assign funct_s       = instr_in[FUNCTION_WIDTH-1:0];
    assign imm_s         = instr_in[15:0];
    assign unused_bits_s = ^instr_in[10:6];

    assign is_rtype_s = (opcode_s == R_TYPE_OPCODE);
    assign is_load_s  = (opcode_s == LW_OPCODE);
    assign is_store_s = (opcode_s == SW_OPCODE);
    assign uses_rs2_s = is_rtype_s || is_store_s;
    assign rd_s       = is_rtype_s ? instr_in[15:11] : instr_in[20:16];

    assign rf_addr_a_out = rs1_s;
    assign rf_addr_b_out = rs2_s;

    imm_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_extend (
        .imm         (imm_s),
        .sign_select (imm_is_signed(opcode_s)),
        .imm_ext     (imm_ext_s)
    );

    // Load-use check against the previously issued instruction; never raised while bubbling.
    always_comb begin
        hazard_s = 1'b0;
        if ((state_r == ST_RUN) && instr_valid_in && trk_load_r && (trk_rd_r != '0)) begin
            hazard_s = (trk_rd_r == rs1_s) || (uses_rs2_s && (trk_rd_r == rs2_s));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign instr_ready_out = ex_ready_in && !hazard_s && !flush_in;
    assign accept_s        = instr_valid_in && instr_ready_out;
    assign load_en_s       = ex_ready_in || flush_in;

    // Payload for the output registers; a non-accepted cycle loads an all-zero bubble.
    always_comb begin
        nxt_opcode_s    = '0;
        nxt_funct_s     = '0;
        nxt_alu_a_s     = '0;
        nxt_alu_b_s     = '0;
        nxt_store_s     = '0;
        nxt_rd_s        = '0;
        nxt_reg_write_s = 1'b0;
        nxt_mem_read_s  = 1'b0;
        nxt_mem_write_s = 1'b0;
        if (accept_s) begin
            nxt_opcode_s    = opcode_s;
            nxt_funct_s     = is_rtype_s ? funct_s : '0;
            nxt_alu_a_s     = rf_data_a_in;
            nxt_rd_s        = rd_s;
            nxt_store_s     = is_store_s ? rf_data_b_in : '0;
            nxt_reg_write_s = writes_rd(opcode_s) && (rd_s != '0);
            nxt_mem_read_s  = is_load_s;
            nxt_mem_write_s = is_store_s;
            if (is_rtype_s) begin
                nxt_alu_b_s = rf_data_b_in;
            end else if (has_imm_operand(opcode_s)) begin
                nxt_alu_b_s = imm_ext_s;
            end else begin
                nxt_alu_b_s = '0;
            end
        end else begin
            nxt_opcode_s = '0;
        end
    end

    // Next state: flush forces RUN, a stalled-free hazard enters BUBBLE for exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        if (flush_in) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN:    state_nxt_s = (hazard_s && ex_ready_in) ? ST_BUBBLE : ST_RUN;
                ST_BUBBLE: state_nxt_s = ST_RUN;
                default:   state_nxt_s = ST_RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Tracker holds whether the instruction now in execute is a load, and its destination.
    always_ff @(posedge clk) begin
        if (rst || flush_in) begin
            trk_load_r <= 1'b0;
            trk_rd_r   <= '0;
        end else if (ex_ready_in) begin
            trk_load_r <= accept_s && is_load_s;
            trk_rd_r   <= accept_s ? rd_s : '0;
        end else if (state_r == ST_BUBBLE) begin
            trk_load_r <= 1'b0;
            trk_rd_r   <= '0;
        end
    end

    // Output registers advance when execute takes data or a flush squashes; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out        <= 1'b0;
            alu_opcode_out   <= '0;
            alu_function_out <= '0;
            alu_data_a_out   <= '0;
            alu_data_b_out   <= '0;
            store_data_out   <= '0;
            rd_addr_out      <= '0;
            reg_write_out    <= 1'b0;
            mem_read_out     <= 1'b0;
            mem_write_out    <= 1'b0;
        end else if (load_en_s) begin
            valid_out        <= accept_s;
            alu_opcode_out   <= nxt_opcode_s;
            alu_function_out <= nxt_funct_s;
            alu_data_a_out   <= nxt_alu_a_s;
            alu_data_b_out   <= nxt_alu_b_s;
            store_data_out   <= nxt_store_s;
            rd_addr_out      <= nxt_rd_s;
            reg_write_out    <= nxt_reg_write_s;
            mem_read_out     <= nxt_mem_read_s;
            mem_write_out    <= nxt_mem_write_s;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: hand-computed expectations for operand forming,
// load-use bubble, execute stall, flush and reset.
module tb_instruction_decode;
    import instruction_decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        instr_valid_in;
    logic        instr_ready_out;
    logic [4:0]  rf_addr_a_out, rf_addr_b_out;
    logic [31:0] rf_data_a_in, rf_data_b_in;
    logic        ex_ready_in, flush_in;
    logic        valid_out;
    logic [5:0]  alu_opcode_out, alu_function_out;
    logic [31:0] alu_data_a_out, alu_data_b_out, store_data_out;
    logic [4:0]  rd_addr_out;
    logic        reg_write_out, mem_read_out, mem_write_out;

    int total_cnt = 0;
    int bad_cnt   = 0;

    instruction_decode dut (
        .clk              (clk),
        .rst              (rst),
        .instr_in         (instr_in),
        .instr_valid_in   (instr_valid_in),
        .instr_ready_out  (instr_ready_out),
        .rf_addr_a_out    (rf_addr_a_out),
        .rf_addr_b_out    (rf_addr_b_out),
        .rf_data_a_in     (rf_data_a_in),
        .rf_data_b_in     (rf_data_b_in),
        .ex_ready_in      (ex_ready_in),
        .flush_in         (flush_in),
        .valid_out        (valid_out),
        .alu_opcode_out   (alu_opcode_out),
        .alu_function_out (alu_function_out),
        .alu_data_a_out   (alu_data_a_out),
        .alu_data_b_out   (alu_data_b_out),
        .store_data_out   (store_data_out),
        .rd_addr_out      (rd_addr_out),
        .reg_write_out    (reg_write_out),
        .mem_read_out     (mem_read_out),
        .mem_write_out    (mem_write_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] r_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [4:0] rd, input logic [5:0] funct);
        r_instr = {R_TYPE_OPCODE, rs1, rs2, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_instr(input logic [5:0] op, input logic [4:0] rs1,
                                            input logic [4:0] rd, input logic [15:0] imm);
        i_instr = {op, rs1, rd, imm};
    endfunction

    initial begin
        rst = 1'b1; flush_in = 1'b0; ex_ready_in = 1'b1; instr_valid_in = 1'b1;
        instr_in = i_instr(ADDI_OPCODE, 5'd1, 5'd2, 16'h1234);
        rf_data_a_in = 32'd55; rf_data_b_in = 32'd66;
        tick(); tick();
        check_val("rst_valid", {31'd0, valid_out}, 32'd0);
        check_val("rst_alu_b", alu_data_b_out, 32'd0);
        check_val("rst_rd", {27'd0, rd_addr_out}, 32'd0);
        check_val("rst_regw", {31'd0, reg_write_out}, 32'd0);

        // ADDI rd=3 rs1=1 imm=0xFFFF
        rst = 1'b0;
        instr_in = i_instr(ADDI_OPCODE, 5'd1, 5'd3, 16'hFFFF);
        rf_data_a_in = 32'd10; rf_data_b_in = 32'd77;
        #1;
        check_val("addi_rfa", {27'd0, rf_addr_a_out}, 32'd1);
        check_val("addi_rfb", {27'd0, rf_addr_b_out}, 32'd3);
        check_val("addi_ready", {31'd0, instr_ready_out}, 32'd1);
        tick();
        check_val("addi_valid", {31'd0, valid_out}, 32'd1);
        check_val("addi_a", alu_data_a_out, 32'd10);
        check_val("addi_b", alu_data_b_out, 32'hFFFF_FFFF);
        check_val("addi_regw", {31'd0, reg_write_out}, 32'd1);
        check_val("addi_rd", {27'd0, rd_addr_out}, 32'd3);
        check_val("addi_op", {26'd0, alu_opcode_out}, {26'd0, ADDI_OPCODE});
        check_val("addi_fn", {26'd0, alu_function_out}, 32'd0);

        // ORI zero-extends
        instr_in = i_instr(ORI_OPCODE, 5'd2, 5'd5, 16'h8000);
        tick();
        check_val("ori_b", alu_data_b_out, 32'h0000_8000);
        check_val("ori_regw", {31'd0, reg_write_out}, 32'd1);

        // Unknown opcode: no operand B, no write
        instr_in = i_instr(6'h3F, 5'd2, 5'd6, 16'h00FF);
        tick();
        check_val("unk_b", alu_data_b_out, 32'd0);
        check_val("unk_regw", {31'd0, reg_write_out}, 32'd0);

        // LW rd=4 then ADD rs1=4: one bubble
        instr_in = i_instr(LW_OPCODE, 5'd2, 5'd4, 16'h0010);
        tick();
        check_val("lw_valid", {31'd0, valid_out}, 32'd1);
        check_val("lw_mrd", {31'd0, mem_read_out}, 32'd1);
        check_val("lw_b", alu_data_b_out, 32'h0000_0010);
        instr_in = r_instr(5'd4, 5'd6, 5'd7, 6'h20);
        rf_data_a_in = 32'd100; rf_data_b_in = 32'd200;
        #1;
        check_val("lu_ready0", {31'd0, instr_ready_out}, 32'd0);
        tick();
        check_val("lu_bubble_valid", {31'd0, valid_out}, 32'd0);
        check_val("lu_bubble_regw", {31'd0, reg_write_out}, 32'd0);
        check_val("lu_bubble_ready", {31'd0, instr_ready_out}, 32'd1);
        tick();
        check_val("add_valid", {31'd0, valid_out}, 32'd1);
        check_val("add_rd", {27'd0, rd_addr_out}, 32'd7);
        check_val("add_fn", {26'd0, alu_function_out}, 32'h20);
        check_val("add_b", alu_data_b_out, 32'd200);
        check_val("add_mrd", {31'd0, mem_read_out}, 32'd0);

        // LW rd=4 then ADDI whose rd field equals 4 but rs1 differs: no hazard
        instr_in = i_instr(LW_OPCODE, 5'd2, 5'd4, 16'h0000);
        tick();
        instr_in = i_instr(ADDI_OPCODE, 5'd2, 5'd4, 16'h0001);
        #1;
        check_val("irs2_nohaz", {31'd0, instr_ready_out}, 32'd1);
        tick();

        // SW, then execute stalls for three cycles
        instr_in = i_instr(SW_OPCODE, 5'd1, 5'd9, 16'hFFFC);
        rf_data_b_in = 32'h0000_1234;
        tick();
        check_val("sw_mwr", {31'd0, mem_write_out}, 32'd1);
        check_val("sw_store", store_data_out, 32'h0000_1234);
        check_val("sw_b", alu_data_b_out, 32'hFFFF_FFFC);
        check_val("sw_regw", {31'd0, reg_write_out}, 32'd0);
        ex_ready_in = 1'b0;
        instr_in = i_instr(BEQZ_OPCODE, 5'd3, 5'd0, 16'h0040);
        rf_data_b_in = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("stall_ready", {31'd0, instr_ready_out}, 32'd0);
            tick();
            check_val("stall_valid", {31'd0, valid_out}, 32'd1);
            check_val("stall_store", store_data_out, 32'h0000_1234);
        end
        ex_ready_in = 1'b1;
        #1;
        check_val("release_ready", {31'd0, instr_ready_out}, 32'd1);
        tick();
        check_val("beqz_valid", {31'd0, valid_out}, 32'd1);
        check_val("beqz_op", {26'd0, alu_opcode_out}, {26'd0, BEQZ_OPCODE});
        check_val("beqz_mwr", {31'd0, mem_write_out}, 32'd0);
        check_val("beqz_b", alu_data_b_out, 32'd0);

        // Flush during BUBBLE
        instr_in = i_instr(LW_OPCODE, 5'd2, 5'd8, 16'h0004);
        tick();
        instr_in = i_instr(ADDI_OPCODE, 5'd8, 5'd9, 16'h0002);
        tick();
        check_val("fb_bubble", {31'd0, valid_out}, 32'd0);
        flush_in = 1'b1;
        #1;
        check_val("fb_ready", {31'd0, instr_ready_out}, 32'd0);
        tick();
        check_val("fb_valid", {31'd0, valid_out}, 32'd0);
        flush_in = 1'b0;
        #1;
        check_val("fb_noagain", {31'd0, instr_ready_out}, 32'd1);
        tick();
        check_val("fb_issue", {31'd0, valid_out}, 32'd1);
        check_val("fb_rd", {27'd0, rd_addr_out}, 32'd9);

        // Flush overrides execute stall
        ex_ready_in = 1'b0; flush_in = 1'b1;
        tick();
        check_val("fstall_valid", {31'd0, valid_out}, 32'd0);
        ex_ready_in = 1'b1; flush_in = 1'b0;

        // R-type with rd=0
        instr_in = r_instr(5'd1, 5'd2, 5'd0, 6'h20);
        tick();
        check_val("rd0_valid", {31'd0, valid_out}, 32'd1);
        check_val("rd0_regw", {31'd0, reg_write_out}, 32'd0);

        // Reset in the middle of a bubble
        instr_in = i_instr(LW_OPCODE, 5'd2, 5'd4, 16'h0008);
        tick();
        instr_in = r_instr(5'd4, 5'd6, 5'd7, 6'h22);
        tick();
        rst = 1'b1;
        tick();
        check_val("mrst_valid", {31'd0, valid_out}, 32'd0);
        check_val("mrst_op", {26'd0, alu_opcode_out}, 32'd0);
        check_val("mrst_a", alu_data_a_out, 32'd0);
        check_val("mrst_mrd", {31'd0, mem_read_out}, 32'd0);
        rst = 1'b0;
        #1;
        check_val("mrst_ready", {31'd0, instr_ready_out}, 32'd1);
        tick();
        check_val("mrst_issue", {31'd0, valid_out}, 32'd1);
        check_val("mrst_fn", {26'd0, alu_function_out}, 32'h22);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
